// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NUM_SRC per-source result FIFOs feeding WB_WIDTH lanes.
// Optional stall counter output enabled by defining WB_ARB_STALL_CNT_EN.
module wb_arbiter #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned WB_WIDTH  = 2,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned PREG_W    = 7,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic [NUM_SRC-1:0]               in_valid,
  output logic [NUM_SRC-1:0]               in_ready,
  input  logic [NUM_SRC-1:0][PREG_W-1:0]   in_phys_rd,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]   in_data,
  output logic [WB_WIDTH-1:0]              wb_valid,
  output logic [WB_WIDTH-1:0][PREG_W-1:0]  wb_phys_rd,
  output logic [WB_WIDTH-1:0][DATA_W-1:0]  wb_data
`ifdef WB_ARB_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_cnt
`endif
);

  localparam int unsigned SrcW  = $clog2(NUM_SRC);
  localparam int unsigned AddrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  typedef struct packed {
    logic [PREG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t [NUM_SRC-1:0][BUF_DEPTH-1:0] mem_q, mem_d;
  logic [NUM_SRC-1:0][AddrW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [NUM_SRC-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [SrcW-1:0]                     rr_ptr_q, rr_ptr_d;
  logic                                ready_q;
  logic [NUM_SRC-1:0]                  push;
  logic [NUM_SRC-1:0]                  grant;
  logic                                any_grant;
  logic                                stall;
  logic [SrcW-1:0]                     last_src;

  // Ready is held low until the first edge after reset release.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      in_ready[i] = ready_q & (cnt_q[i] != CntW'(BUF_DEPTH));
    end
  end

  assign push = in_valid & in_ready & {NUM_SRC{~flush}};

  // Scan from rr_ptr, handing non-empty heads to lanes contiguously from lane 0.
  always_comb begin
    int unsigned lane;
    int unsigned src;
    grant      = '0;
    wb_valid   = '0;
    wb_phys_rd = '0;
    wb_data    = '0;
    any_grant  = 1'b0;
    stall      = 1'b0;
    last_src   = '0;
    lane       = 0;
    src        = 0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      src = (32'(rr_ptr_q) + j) % NUM_SRC;
      if (cnt_q[src] != '0) begin
        if (lane < WB_WIDTH) begin
          grant[src]       = 1'b1;
          wb_valid[lane]   = 1'b1;
          wb_phys_rd[lane] = mem_q[src][rd_q[src]].rd;
          wb_data[lane]    = mem_q[src][rd_q[src]].data;
          last_src         = SrcW'(src);
          any_grant        = 1'b1;
          lane             = lane + 1;
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (any_grant) begin
      rr_ptr_d = (last_src == SrcW'(NUM_SRC - 1)) ? '0 : last_src + SrcW'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (flush) begin
        wr_d[i]  = '0;
        rd_d[i]  = '0;
        cnt_d[i] = '0;
      end else begin
        if (push[i]) begin
          mem_d[i][wr_q[i]] = '{rd: in_phys_rd[i], data: in_data[i]};
          wr_d[i]           = wr_q[i] + 1'b1;
        end
        if (grant[i]) begin
          rd_d[i] = rd_q[i] + 1'b1;
        end
        cnt_d[i] = cnt_q[i] + CntW'(push[i]) - CntW'(grant[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      ready_q  <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef WB_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: one 4x2 instance and one 4x1 instance.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic [3:0]            a_in_valid, a_in_ready;
  logic [3:0][6:0]       a_in_rd;
  logic [3:0][31:0]      a_in_data;
  logic [1:0]            a_wb_valid;
  logic [1:0][6:0]       a_wb_rd;
  logic [1:0][31:0]      a_wb_data;

  logic [3:0]            b_in_valid, b_in_ready;
  logic [3:0][6:0]       b_in_rd;
  logic [3:0][31:0]      b_in_data;
  logic [0:0]            b_wb_valid;
  logic [0:0][6:0]       b_wb_rd;
  logic [0:0][31:0]      b_wb_data;

`ifdef WB_ARB_STALL_CNT_EN
  logic [31:0] a_stall_cnt, b_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_SRC(4), .WB_WIDTH(2), .BUF_DEPTH(4), .PREG_W(7), .DATA_W(32)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_phys_rd (a_in_rd),
    .in_data    (a_in_data),
    .wb_valid   (a_wb_valid),
    .wb_phys_rd (a_wb_rd),
    .wb_data    (a_wb_data)
`ifdef WB_ARB_STALL_CNT_EN
    ,
    .stall_cnt  (a_stall_cnt)
`endif
  );

  wb_arbiter #(.NUM_SRC(4), .WB_WIDTH(1), .BUF_DEPTH(4), .PREG_W(7), .DATA_W(32)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_phys_rd (b_in_rd),
    .in_data    (b_in_data),
    .wb_valid   (b_wb_valid),
    .wb_phys_rd (b_wb_rd),
    .wb_data    (b_wb_data)
`ifdef WB_ARB_STALL_CNT_EN
    ,
    .stall_cnt  (b_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  int got;

  initial begin
    a_in_valid = '0;
    a_in_rd    = '0;
    a_in_data  = '0;
    b_in_valid = '0;
    b_in_rd    = '0;
    b_in_data  = '0;
    for (int i = 0; i < 4; i++) b_in_rd[i] = 7'(8 + i);

    // Reset state
    step();
    step();
    check("rst_ready_a", 64'(a_in_ready), 64'h0);
    check("rst_ready_b", 64'(b_in_ready), 64'h0);
    check("rst_wbv_a", 64'(a_wb_valid), 64'h0);
    #3 rst_n = 1'b1;
    step();
    check("rel_ready_a", 64'(a_in_ready), 64'hF);
    check("rel_wbv_a", 64'(a_wb_valid), 64'h0);
    check("rel_wbrd_a", 64'(a_wb_rd), 64'h0);
    check("rel_wbdata_a", 64'(a_wb_data), 64'h0);

    // Single push from src1
    a_in_valid = 4'b0010;
    a_in_rd[1] = 7'd5;
    a_in_data[1] = 32'hDEADBEEF;
    step();
    a_in_valid = '0;
    check("single_v", 64'(a_wb_valid), 64'h1);
    check("single_rd", 64'(a_wb_rd[0]), 64'd5);
    check("single_data", 64'(a_wb_data[0]), 64'hDEADBEEF);
    check("single_l1_data", 64'(a_wb_data[1]), 64'h0);
    step();
    check("single_drain", 64'(a_wb_valid), 64'h0);
    do_flush();

    // Contention: all four push with rr_ptr = 0
    a_in_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a_in_rd[i]   = 7'(10 + i);
      a_in_data[i] = 32'h100 + 32'(i);
    end
    step();
    a_in_valid = '0;
    check("cont1_v", 64'(a_wb_valid), 64'h3);
    check("cont1_l0", 64'(a_wb_rd[0]), 64'd10);
    check("cont1_l1", 64'(a_wb_rd[1]), 64'd11);
    check("cont1_d1", 64'(a_wb_data[1]), 64'h101);
    step();
    check("cont2_v", 64'(a_wb_valid), 64'h3);
    check("cont2_l0", 64'(a_wb_rd[0]), 64'd12);
    check("cont2_l1", 64'(a_wb_rd[1]), 64'd13);
    step();
    check("cont3_v", 64'(a_wb_valid), 64'h0);
`ifdef WB_ARB_STALL_CNT_EN
    check("cont_stall", 64'(a_stall_cnt), 64'd1);
`endif
    // rr_ptr back at 0: src0 must precede src3
    a_in_valid = 4'b1001;
    a_in_rd[0] = 7'd20;
    a_in_rd[3] = 7'd23;
    step();
    a_in_valid = '0;
    check("rr0_l0", 64'(a_wb_rd[0]), 64'd20);
    check("rr0_l1", 64'(a_wb_rd[1]), 64'd23);
    step();

    // Fairness on the single-lane instance
    do_flush();
    b_in_valid = 4'b1001;
    step();
    for (int k = 0; k < 8; k++) begin
      check("fair_v", 64'(b_wb_valid), 64'h1);
      check("fair_src", 64'(b_wb_rd[0]), (k % 2 == 0) ? 64'd8 : 64'd11);
      step();
    end
    b_in_valid = '0;
    do_flush();

    // Full: all four saturate, src2 fills to depth 4
    b_in_valid = 4'hF;
    for (int e = 1; e <= 6; e++) begin
      b_in_data[2] = 32'hA0 + 32'(e - 1);
      step();
      if (e == 4) check("full_rdy_e4", 64'(b_in_ready), 64'h7);
      if (e == 5) check("full_rdy_e5", 64'(b_in_ready), 64'h8);
      if (e == 6) check("full_rdy_e6", 64'(b_in_ready), 64'h1);
    end
    b_in_valid = '0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (b_wb_valid[0] && b_wb_rd[0] == 7'd10) begin
        check("full_order", 64'(b_wb_data[0]), 64'hA1 + 64'(got));
        got++;
      end
      step();
    end
    check("full_cnt", 64'(got), 64'd4);
    check("full_empty", 64'(b_wb_valid), 64'h0);

    // Flush discards buffered entries and the same-cycle push
    do_flush();
    for (int i = 0; i < 4; i++) a_in_rd[i] = 7'(40 + i);
    a_in_valid = 4'b0001;
    a_in_data[0] = 32'h30;
    step();
    check("fl_e1", 64'(a_wb_data[0]), 64'h30);
    a_in_data[0] = 32'h31;
    step();
    check("fl_e2", 64'(a_wb_data[0]), 64'h31);
    a_in_valid = 4'hF;
    a_in_data[0] = 32'h32;
    step();
    check("fl_cyc_v", 64'(a_wb_valid), 64'h3);
    check("fl_cyc_l0", 64'(a_wb_rd[0]), 64'd41);
    check("fl_cyc_l1", 64'(a_wb_rd[1]), 64'd42);
    a_in_valid = 4'b0001;
    a_in_data[0] = 32'h33;
    flush = 1'b1;
    step();
    flush = 1'b0;
    a_in_valid = '0;
    check("fl_after_v", 64'(a_wb_valid), 64'h0);
    check("fl_after_rdy", 64'(a_in_ready), 64'hF);
    step();
    check("fl_after2_v", 64'(a_wb_valid), 64'h0);

    // Asynchronous reset mid-burst
    a_in_valid = 4'hF;
    for (int i = 0; i < 4; i++) a_in_rd[i] = 7'(50 + i);
    step();
    a_in_valid = '0;
    check("ar_pre_v", 64'(a_wb_valid), 64'h3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_v", 64'(a_wb_valid), 64'h0);
    check("ar_rdy", 64'(a_in_ready), 64'h0);
    #3 rst_n = 1'b1;
    step();
    check("ar_rel_rdy", 64'(a_in_ready), 64'hF);
    check("ar_rel_v", 64'(a_wb_valid), 64'h0);
`ifdef WB_ARB_STALL_CNT_EN
    check("ar_stall", 64'(a_stall_cnt), 64'd0);
`endif
    step();
    check("ar_rel2_v", 64'(a_wb_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
